// File: rtl/soc_reset_sequencer_if.sv
// rtl/soc_reset_sequencer_if.sv - board-side signal bundle between pins, SOC and the reset sequencer
// The rx line exists only when RISCO_UART_BREAK_RESET_EN is defined.
interface soc_reset_sequencer_if;
  logic       btn_in;
  logic       sw_reset_req;
`ifdef RISCO_UART_BREAK_RESET_EN
  logic       rx;
`endif
  logic       soc_reset;
  logic       ready;
  logic [1:0] reset_cause;

`ifdef RISCO_UART_BREAK_RESET_EN
  modport master (
    output btn_in, sw_reset_req, rx,
    input  soc_reset, ready, reset_cause
  );

  modport slave (
    input  btn_in, sw_reset_req, rx,
    output soc_reset, ready, reset_cause
  );
`else
  modport master (
    output btn_in, sw_reset_req,
    input  soc_reset, ready, reset_cause
  );

  modport slave (
    input  btn_in, sw_reset_req,
    output soc_reset, ready, reset_cause
  );
`endif
endinterface

// File: rtl/soc_reset_sequencer.sv
// rtl/soc_reset_sequencer.sv - SOC reset generator: power-on stretch, debounced button, software request
// UART break reset is compiled in when RISCO_UART_BREAK_RESET_EN is defined.
module soc_reset_sequencer #(
  parameter int POR_CYCLES      = 1024,
  parameter int HOLD_CYCLES     = 64,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_HIGH = 1'b1,
  parameter int BREAK_CYCLES    = 52083
) (
  input logic                  clk,
  input logic                  reset,
  soc_reset_sequencer_if.slave bus
);

  localparam int CNT_MAX = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_POR          = 2'd0,
    ST_ASSERT       = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_RUN          = 2'd3
  } state_t;

  // Button path works in "pressed = 1" polarity from the first flop onwards
  logic            w_btn_raw;
  logic            r_btn_meta;
  logic            r_btn_sync;
  logic            r_btn_stable;
  logic            r_press_evt;
  logic [DB_W-1:0] r_db_cnt;

  assign w_btn_raw = BTN_ACTIVE_HIGH ? bus.btn_in : ~bus.btn_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_meta   <= 1'b0;
      r_btn_sync   <= 1'b0;
      r_btn_stable <= 1'b0;
      r_press_evt  <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_btn_meta  <= w_btn_raw;
      r_btn_sync  <= r_btn_meta;
      r_press_evt <= 1'b0;
      if (r_btn_sync == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_stable <= r_btn_sync;
        r_db_cnt     <= '0;
        r_press_evt  <= r_btn_sync;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  logic w_break_evt;

`ifdef RISCO_UART_BREAK_RESET_EN
  localparam int BRK_W = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_CYCLES - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_brk_armed;
  logic [BRK_W-1:0] r_brk_cnt;

  // Disarmed after firing until rx idles high, so one long break gives one reset
  assign w_break_evt = r_brk_armed && !r_rx_sync && (r_brk_cnt == BRK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_brk_armed <= 1'b1;
      r_brk_cnt   <= '0;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      if (r_rx_sync) begin
        r_brk_cnt   <= '0;
        r_brk_armed <= 1'b1;
      end else if (r_brk_armed) begin
        if (r_brk_cnt == BRK_LAST) begin
          r_brk_armed <= 1'b0;
          r_brk_cnt   <= '0;
        end else begin
          r_brk_cnt <= r_brk_cnt + BRK_W'(1);
        end
      end
    end
  end
`else
  // Break detection compiled out; the parameter stays referenced so both builds share one port list
  assign w_break_evt = 1'b0 & (BREAK_CYCLES > 0);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_POR;
      r_cnt   <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_POR: begin
        if (r_cnt == POR_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RUN: begin
        // Fixed priority; a losing request in the same cycle is simply dropped
        if (r_press_evt) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_cause_nxt = 2'b01;
        end else if (w_break_evt) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_cause_nxt = 2'b11;
        end else if (bus.sw_reset_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_cause_nxt = 2'b10;
        end
      end
      ST_ASSERT: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_btn_stable ? ST_WAIT_RELEASE : ST_RUN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!r_btn_stable) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_POR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.soc_reset   = (r_state != ST_RUN);
    bus.ready       = (r_state == ST_RUN);
    bus.reset_cause = r_cause;
  end

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// tb/tb_soc_reset_sequencer.sv - vector table, directed corner cases and random trials for soc_reset_sequencer
// Break-reset vectors are included when RISCO_UART_BREAK_RESET_EN is defined.
module tb_soc_reset_sequencer;

  localparam int POR_C  = 16;
  localparam int HOLD_C = 8;
  localparam int DB_C   = 4;
  localparam int BRK_C  = 20;
  localparam int SYNC_C = 2;

  logic       clk = 1'b0;
  logic       reset;
  int         total = 0;
  int         bad = 0;
  logic [1:0] m_cause;

  soc_reset_sequencer_if bus ();

  soc_reset_sequencer #(
    .POR_CYCLES      (POR_C),
    .HOLD_CYCLES     (HOLD_C),
    .DEBOUNCE_CYCLES (DB_C),
    .BTN_ACTIVE_HIGH (1'b1),
    .BREAK_CYCLES    (BRK_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 software, 1 button, 3 rx break
    int         len;
    int         sw_at;
    int         sw2_at;
    int         lo;
    int         hi;
    logic [1:0] cause;
  } vec_t;

  task automatic check(input string name, input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d want %0d", name, what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: reset window [lo,hi] in cycles after stimulus start, or lo=-1 when no reset occurs
  function automatic void model(input int kind, input int len, input int sw_at,
                                output int lo, output int hi, output logic [1:0] cause);
    lo = -1;
    hi = -1;
    cause = m_cause;
    if (kind == 1 && len >= DB_C) begin
      lo = SYNC_C + DB_C;
      hi = (lo + HOLD_C - 1 > len + SYNC_C + DB_C - 1) ? lo + HOLD_C - 1 : len + SYNC_C + DB_C - 1;
      cause = 2'b01;
    end else if (kind == 3 && len >= BRK_C) begin
      lo = SYNC_C + BRK_C - 1;
      hi = lo + HOLD_C - 1;
      cause = 2'b11;
    end else if (sw_at >= 0) begin
      lo = sw_at;
      hi = lo + HOLD_C - 1;
      cause = 2'b10;
    end
  endfunction

  task automatic run_trial(input string name, input vec_t v);
    int win;
    int first_hi;
    int last_hi;
    int n_hi;
    int rdy_bad;
    win = ((v.hi > v.len) ? v.hi : v.len) + 14;
    first_hi = -1;
    last_hi = -1;
    n_hi = 0;
    rdy_bad = 0;
    for (int k = 0; k < win; k++) begin
      bus.btn_in = (v.kind == 1) && (k < v.len);
      bus.sw_reset_req = (k == v.sw_at) || (k == v.sw2_at);
`ifdef RISCO_UART_BREAK_RESET_EN
      bus.rx = !((v.kind == 3) && (k < v.len));
`endif
      tick();
      if (bus.soc_reset) begin
        if (first_hi < 0) first_hi = k;
        last_hi = k;
        n_hi++;
      end
      if (bus.ready == bus.soc_reset) rdy_bad++;
    end
    bus.btn_in = 1'b0;
    bus.sw_reset_req = 1'b0;
`ifdef RISCO_UART_BREAK_RESET_EN
    bus.rx = 1'b1;
`endif
    check(name, "first_high", first_hi, v.lo);
    check(name, "last_high", last_hi, v.hi);
    check(name, "high_cycles", n_hi, (v.lo < 0) ? 0 : v.hi - v.lo + 1);
    check(name, "ready_vs_reset", rdy_bad, 0);
    check(name, "cause", int'(bus.reset_cause), int'(v.cause));
    m_cause = v.cause;
  endtask

  task automatic por_release(input string name);
    int n;
    n = 0;
    reset = 1'b0;
    for (int i = 0; i < 40 && bus.soc_reset; i++) begin
      n++;
      tick();
    end
    check(name, "por_high_cycles", n, POR_C);
    check(name, "ready", int'(bus.ready), 1);
    check(name, "cause", int'(bus.reset_cause), 0);
    m_cause = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[$];
    vec_t       v;
    logic [6:0] bpat;
    int         n;
    int         kind;

    reset = 1'b1;
    bus.btn_in = 1'b0;
    bus.sw_reset_req = 1'b0;
`ifdef RISCO_UART_BREAK_RESET_EN
    bus.rx = 1'b1;
`endif
    m_cause = 2'b00;

    vecs.push_back('{0,  0,  0, -1,  0,  7, 2'b10});
    vecs.push_back('{1,  3, -1, -1, -1, -1, 2'b10});
    vecs.push_back('{1,  4, -1, -1,  6, 13, 2'b01});
    vecs.push_back('{0,  0,  0,  4,  0,  7, 2'b10});
    vecs.push_back('{0,  0,  0,  8,  0,  7, 2'b10});
    vecs.push_back('{1,  8, -1, -1,  6, 13, 2'b01});
    vecs.push_back('{1,  9, -1, -1,  6, 14, 2'b01});
    vecs.push_back('{1, 30, -1, 20,  6, 35, 2'b01});
    vecs.push_back('{1, 10,  6, -1,  6, 15, 2'b01});
`ifdef RISCO_UART_BREAK_RESET_EN
    vecs.push_back('{3, 40, -1, -1, 21, 28, 2'b11});
    vecs.push_back('{0,  0,  2, -1,  2,  9, 2'b10});
    vecs.push_back('{3, 19, -1, -1, -1, -1, 2'b10});
    vecs.push_back('{3, 20, -1, 21, 21, 28, 2'b11});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "soc_reset", int'(bus.soc_reset), 1);
    check("reset", "ready", int'(bus.ready), 0);
    check("reset", "cause", int'(bus.reset_cause), 0);
    por_release("por");

    // Bounce: 2 high, 1 low, 3 high, 1 low must never be accepted
    bpat = 7'b0111011;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      bus.btn_in = (k < 7) ? bpat[k] : 1'b0;
      tick();
      if (bus.soc_reset) n++;
    end
    check("bounce", "high_cycles", n, 0);
    run_trial("bounce_press", '{1, 6, -1, -1, 6, 13, 2'b01});

    for (int i = 0; i < vecs.size(); i++) begin
      run_trial($sformatf("vec%0d", i), vecs[i]);
    end

    // Block reset during the third ASSERT cycle aborts straight back to POR
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    check("abort", "cause_before", int'(bus.reset_cause), 2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort", "soc_reset", int'(bus.soc_reset), 1);
    check("abort", "ready", int'(bus.ready), 0);
    check("abort", "cause", int'(bus.reset_cause), 0);
    por_release("abort_por");

    for (int t = 0; t < 30; t++) begin
`ifdef RISCO_UART_BREAK_RESET_EN
      kind = $urandom_range(0, 3);
`else
      kind = $urandom_range(0, 2);
`endif
      v.sw_at = -1;
      v.len = 0;
      case (kind)
        0: begin v.kind = 0; v.sw_at = $urandom_range(0, 3); end
        1: begin v.kind = 1; v.len = $urandom_range(4, 40); end
        2: begin v.kind = 1; v.len = $urandom_range(4, 40); v.sw_at = SYNC_C + DB_C; end
        default: begin v.kind = 3; v.len = $urandom_range(10, 45); end
      endcase
      model(v.kind, v.len, v.sw_at, v.lo, v.hi, v.cause);
      v.sw2_at = (v.lo >= 0 && $urandom_range(0, 1) == 1) ? $urandom_range(v.lo + 1, v.hi) : -1;
      run_trial($sformatf("rand%0d", t), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
